redundancy_selector: RTL and testbench
======================================

Name: redundancy_selector

Overview:
- N-way successor to the dual-CPU switch logic.
- Watches NUM_CPU active-low health lines and counts error events per CPU in renormalising counters.
- Selects the active CPU, with fault failover, hysteresis, post-switch holdoff and a forced-selection override.
- Drives the selection index and one-hot mux/GPIO enables consumed by the UART routing and LED logic.

Parameters:
- NUM_CPU, 4: number of redundant CPUs, 2..16.
- ERR_W, 8: width of each error counter.
- HYST, 2: error-count margin a healthy CPU needs before it preempts the current one.
- HOLDOFF, 16: cycles after any switch during which only a fault of the selected CPU can cause a further switch.
- SEL_W, clog2(NUM_CPU): width of the selection index.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- io_n  in  NUM_CPU  health lines, asynchronous, 0 = CPU i faulted.
- force_swi  in  1  forced-selection mode while high.
- force_sel  in  SEL_W  CPU index to use while force_swi = 1.
- sel  out  SEL_W  selected CPU index.
- sel_oh  out  NUM_CPU  one-hot form of sel.
- switch_pulse  out  1  high for exactly one cycle when sel changes.
- all_fault  out  1  every CPU is currently faulted.
- err_cnt  out  NUM_CPU*ERR_W  packed error counters; CPU i at bits [i*ERR_W +: ERR_W].

Behaviour:
- Decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - sel = 0, sel_oh = 1, switch_pulse = 0, all_fault = 0.
  - All counters 0, holdoff counter 0, state RUN.
  - Synchroniser flops reset to 1 (healthy).
- Input conditioning:
  - io_n passes through 2 flops, giving io_s; fault[i] = ~io_s[i].
  - A third flop gives fault_d; an error event is fault & ~fault_d.
- Counter update, each cycle, in priority order:
  - force_swi = 1: all counters cleared.
  - Else if any counter == 2^ERR_W-1: every counter becomes (cnt>>1) + event[i]. This cannot overflow.
  - Else cnt[i] += event[i].
- Best candidate: the non-faulted CPU with the lowest count; ties go to the lowest index. There is none if all CPUs are faulted.
- all_fault is registered, equal to the AND of all fault bits.
- FSM states, encoded in the package: RUN, HOLD, FORCED, NONE.
  - Any state with force_swi = 1 goes to FORCED. sel takes force_sel if force_sel < NUM_CPU; otherwise sel is unchanged.
  - RUN:
    - Selected CPU faulted and a best exists: sel = best, go to HOLD.
    - No best: go to NONE, sel held.
    - Else if cnt[best] + HYST < cnt[sel], compared at ERR_W+1 bits: sel = best, go to HOLD.
  - HOLD:
    - The holdoff counter is loaded with HOLDOFF-1 on entry and decrements each cycle; at 0 go to RUN.
    - Selected CPU faulted and a best exists: switch and reload the counter.
    - No best: go to NONE.
    - The hysteresis preemption is suppressed in HOLD.
  - FORCED:
    - sel tracks force_sel, even onto a faulted CPU.
    - When force_swi falls, go to HOLD, counter reloaded.
  - NONE:
    - sel held.
    - When a best exists: sel = best and go to HOLD. If best equals the old sel, there is no pulse.
- switch_pulse is registered and fires on the cycle sel changes. No pulse when the new value equals the old one.
- sel_oh is always consistent with sel in the same cycle.
- Latency: an io_n edge changes sel 3 clocks later (2 sync flops + 1 decision register).
- A fault and a better-count event in the same cycle: failover wins, with the target chosen by the best rule.
- rst mid-HOLD or mid-FORCED returns to the reset values on the next edge.

Decomposition:
- Package redundancy_pkg holds:
  - FSM state typedef.
  - clog2 function.
  - Default constants DEF_NUM_CPU, DEF_ERR_W, DEF_HYST, DEF_HOLDOFF.
- One sub-module, cpu_err_tracker, instantiated NUM_CPU times:
  - Contains the 2-flop sync, edge detect and counter.
  - Inputs: clr, any_sat. Outputs: fault, cnt, sat.
- The best-candidate selection and FSM stay in the top level.

Test Plan (bench configuration: NUM_CPU=4, ERR_W=8, HYST=2, HOLDOFF=16):
- Reset: all io_n=1, rst high 2 cycles → sel=0, sel_oh=4'b0001, err_cnt all 0, switch_pulse=0, state RUN.
- Failover: hold io_n[0]=0 → on the 3rd clk sel=1, one-cycle switch_pulse, cnt[0]=1, state HOLD. Release → state RUN after 16 cycles, sel stays 1.
- Hysteresis: pulse io_n[1] low 3 times (cnt[1]=3, cnt[0]=1, cnt[0]+2<3 false) → sel stays 1. A 4th pulse → sel=0 after the holdoff expires.
- Force: force_swi=1, force_sel=3 with io_n[3]=0 → sel=3, all counters 0. force_sel=7 is illegal for SEL_W=2 wrap; use force_sel out of range on NUM_CPU=3 → sel unchanged. Drop force → HOLD, then failover from 3 to 0.
- Saturation: drive 255 events on CPU 2 with cnt[0]=10 → next event: cnt[2]=128, cnt[0]=5. No wrap to 0.
- All fault: io_n=4'b0000 → all_fault=1, state NONE, sel held. Set io_n[2]=1 → sel=2, pulse, state HOLD.

Source files
------------

// File: rtl/redundancy_pkg.sv
// Shared definitions for the N-way redundancy selector.
//   state_t  : selector FSM states (RUN, HOLD, FORCED, NONE)
//   clog2    : ceiling log2, used to size index and holdoff fields
//   DEF_*    : default parameter values for the selector and its trackers
package redundancy_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    FORCED = 2'd2,
    NONE   = 2'd3
  } state_t;

  localparam int DEF_NUM_CPU = 4;
  localparam int DEF_ERR_W   = 8;
  localparam int DEF_HYST    = 2;
  localparam int DEF_HOLDOFF = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/redundancy_selector_if.sv
// Bus between the redundancy selector and its environment.
//   io_n         : per-CPU health lines, active-low, asynchronous
//   force_swi    : forced-selection mode while high
//   force_sel    : CPU index used while force_swi is high
//   sel          : selected CPU index
//   sel_oh       : one-hot form of sel
//   switch_pulse : one-cycle strobe when sel changes
//   all_fault    : every CPU currently faulted
//   err_cnt      : packed error counters, CPU i at [i*ERR_W +: ERR_W]
// The master side drives the health/force inputs; the slave is the selector.
interface redundancy_selector_if import redundancy_pkg::*; #(
  parameter int NUM_CPU = DEF_NUM_CPU,
  parameter int ERR_W   = DEF_ERR_W,
  parameter int SEL_W   = clog2(NUM_CPU)
);
  logic [NUM_CPU-1:0]       io_n;
  logic                     force_swi;
  logic [SEL_W-1:0]         force_sel;
  logic [SEL_W-1:0]         sel;
  logic [NUM_CPU-1:0]       sel_oh;
  logic                     switch_pulse;
  logic                     all_fault;
  logic [NUM_CPU*ERR_W-1:0] err_cnt;

  modport master (
    output io_n, force_swi, force_sel,
    input  sel, sel_oh, switch_pulse, all_fault, err_cnt
  );

  modport slave (
    input  io_n, force_swi, force_sel,
    output sel, sel_oh, switch_pulse, all_fault, err_cnt
  );
endinterface

// File: rtl/redundancy_selector_cpu_err_tracker.sv
// Per-CPU health conditioning and renormalising error counter.
//   clk, rst : clock and synchronous active-high reset
//   io_n     : raw asynchronous health line (0 = faulted)
//   clr      : clear the counter (forced mode)
//   any_sat  : some counter in the system is saturated; halve this one
//   fault    : synchronised fault level
//   cnt      : current error count
//   sat      : this counter is at its maximum value
module cpu_err_tracker import redundancy_pkg::*; #(
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             io_n,
  input  logic             clr,
  input  logic             any_sat,
  output logic             fault,
  output logic [ERR_W-1:0] cnt,
  output logic             sat
);

  logic             io_p0;
  logic             io_p1;
  logic             io_p2;
  logic             evt;
  logic [ERR_W-1:0] cnt_d;

  assign fault = ~io_p1;
  // Rising edge of the fault level: healthy last cycle, faulted now.
  assign evt   = ~io_p1 & io_p2;
  assign sat   = (cnt == '1);

  // Halving before adding the event keeps the sum below the maximum,
  // so the counter can never wrap.
  always_comb begin
    cnt_d = cnt + ERR_W'(evt);
    if (clr) begin
      cnt_d = '0;
    end else if (any_sat) begin
      cnt_d = (cnt >> 1) + ERR_W'(evt);
    end
  end

  // p0/p1: two-flop synchroniser, p2: previous level for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      io_p0 <= 1'b1;
      io_p1 <= 1'b1;
      io_p2 <= 1'b1;
      cnt   <= '0;
    end else begin
      io_p0 <= io_n;
      io_p1 <= io_p0;
      io_p2 <= io_p1;
      cnt   <= cnt_d;
    end
  end

endmodule

// File: rtl/redundancy_selector.sv
// N-way redundant CPU selector with fault failover, hysteresis-based
// preemption, post-switch holdoff and a forced-selection override.
//   clk, rst : clock and synchronous active-high reset
//   bus      : redundancy_selector_if slave (health lines, force controls,
//              selection index/one-hot, switch strobe, all-fault flag,
//              packed error counters)
module redundancy_selector import redundancy_pkg::*; #(
  parameter int NUM_CPU = DEF_NUM_CPU,
  parameter int ERR_W   = DEF_ERR_W,
  parameter int HYST    = DEF_HYST,
  parameter int HOLDOFF = DEF_HOLDOFF,
  parameter int SEL_W   = clog2(NUM_CPU)
) (
  input  logic                  clk,
  input  logic                  rst,
  redundancy_selector_if.slave  bus
);

  localparam int                HOLD_W    = clog2(HOLDOFF + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);
  localparam logic [ERR_W:0]    HYST_X    = (ERR_W+1)'(HYST);

  logic [NUM_CPU-1:0]       fault;
  logic [NUM_CPU-1:0]       sat;
  logic [ERR_W-1:0]         cnt [NUM_CPU];
  logic [NUM_CPU*ERR_W-1:0] err_flat;
  logic                     any_sat;

  assign any_sat = |sat;

  for (genvar i = 0; i < NUM_CPU; i++) begin : g_cpu
    cpu_err_tracker #(.ERR_W(ERR_W)) u_trk (
      .clk     (clk),
      .rst     (rst),
      .io_n    (bus.io_n[i]),
      .clr     (bus.force_swi),
      .any_sat (any_sat),
      .fault   (fault[i]),
      .cnt     (cnt[i]),
      .sat     (sat[i])
    );
  end

  always_comb begin
    err_flat = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      err_flat[i*ERR_W +: ERR_W] = cnt[i];
    end
  end

  // Best candidate: lowest count among healthy CPUs. Strict '<' keeps
  // the lowest index on ties.
  logic             best_vld;
  logic [SEL_W-1:0] best;
  logic [ERR_W-1:0] best_cnt;

  always_comb begin
    best_vld = 1'b0;
    best     = '0;
    best_cnt = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      if (!fault[i] && (!best_vld || cnt[i] < best_cnt)) begin
        best_vld = 1'b1;
        best     = SEL_W'(i);
        best_cnt = cnt[i];
      end
    end
  end

  state_t            state_q;
  state_t            state_d;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              pulse_q;
  logic              all_fault_q;
  logic              sel_faulted;
  logic              preempt;
  logic [ERR_W:0]    best_x;

  // One extra bit so best + HYST cannot wrap below the current count.
  assign best_x  = {1'b0, best_cnt} + HYST_X;
  assign preempt = best_x < {1'b0, cnt[sel_q]};

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    hold_d      = hold_q;
    sel_faulted = fault[sel_q];
    if (bus.force_swi) begin
      state_d = FORCED;
      // Out-of-range requests leave the selection untouched.
      if ({1'b0, bus.force_sel} < (SEL_W+1)'(NUM_CPU)) begin
        sel_d = bus.force_sel;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (sel_faulted && best_vld) begin
            sel_d   = best;
            state_d = HOLD;
            hold_d  = HOLD_LOAD;
          end else if (!best_vld) begin
            state_d = NONE;
          end else if (preempt) begin
            sel_d   = best;
            state_d = HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
        HOLD: begin
          // Only a fault of the selected CPU may switch during holdoff.
          if (sel_faulted && best_vld) begin
            sel_d  = best;
            hold_d = HOLD_LOAD;
          end else if (!best_vld) begin
            state_d = NONE;
          end else if (hold_q == '0) begin
            state_d = RUN;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        FORCED: begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end
        NONE: begin
          if (best_vld) begin
            sel_d   = best;
            state_d = HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Decision register: selection, holdoff, strobe and all-fault flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      sel_q       <= '0;
      hold_q      <= '0;
      pulse_q     <= 1'b0;
      all_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      hold_q      <= hold_d;
      pulse_q     <= (sel_d != sel_q);
      all_fault_q <= &fault;
    end
  end

  assign bus.sel          = sel_q;
  assign bus.sel_oh       = NUM_CPU'(1) << sel_q;
  assign bus.switch_pulse = pulse_q;
  assign bus.all_fault    = all_fault_q;
  assign bus.err_cnt      = err_flat;

endmodule

// File: tb/tb_redundancy_selector.sv
module tb_redundancy_selector;
  import redundancy_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  redundancy_selector_if #(.NUM_CPU(4), .ERR_W(8), .SEL_W(2)) bus ();
  redundancy_selector_if #(.NUM_CPU(3), .ERR_W(8), .SEL_W(2)) bus3 ();

  redundancy_selector #(
    .NUM_CPU(4), .ERR_W(8), .HYST(2), .HOLDOFF(16), .SEL_W(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  redundancy_selector #(
    .NUM_CPU(3), .ERR_W(8), .HYST(2), .HOLDOFF(16), .SEL_W(2)
  ) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  typedef struct {
    logic        r;
    logic [3:0]  io;
    logic        fs;
    logic [1:0]  fsel;
    int          n;
    logic        chk;
    logic [1:0]  sel;
    logic        p;
    logic        af;
    state_t      st;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];
  vec_t v;
  int   ncmp = 0;
  int   nfail = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] io, input logic fs,
                              input logic [1:0] fsel, input int n, input logic chk,
                              input logic [1:0] sel, input logic p, input logic af,
                              input state_t st, input logic [31:0] cnt);
    vec_t t;
    t.r = r; t.io = io; t.fs = fs; t.fsel = fsel; t.n = n; t.chk = chk;
    t.sel = sel; t.p = p; t.af = af; t.st = st; t.cnt = cnt;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input int i);
    bus.io_n[i] = 1'b0;
    tick();
    bus.io_n[i] = 1'b1;
    tick();
  endtask

  initial begin
    logic [3:0] oh;

    bus.io_n = 4'hF;  bus.force_swi = 1'b0;  bus.force_sel = 2'd0;
    bus3.io_n = 3'b111; bus3.force_swi = 1'b0; bus3.force_sel = 2'd0;

    // reset
    vq.push_back(mk(1, 4'hF, 0, 0, 2, 1, 0, 0, 0, RUN, 32'h0));
    // failover of CPU0: not yet after 2 clocks, switched on the 3rd
    vq.push_back(mk(0, 4'hE, 0, 0, 2, 1, 0, 0, 0, RUN,  32'h0));
    vq.push_back(mk(0, 4'hE, 0, 0, 1, 1, 1, 1, 0, HOLD, 32'h1));
    vq.push_back(mk(0, 4'hF, 0, 0, 1, 1, 1, 0, 0, HOLD, 32'h1));
    vq.push_back(mk(0, 4'hF, 0, 0, 14, 1, 1, 0, 0, HOLD, 32'h1));
    vq.push_back(mk(0, 4'hF, 0, 0, 1, 1, 1, 0, 0, RUN,  32'h1));
    // CPUs 0,2,3 faulted; CPU1 alone healthy and stays selected
    vq.push_back(mk(0, 4'b0010, 0, 0, 5, 1, 1, 0, 0, RUN, 32'h01010002));
    // three one-cycle faults of CPU1 while the others are down
    for (int k = 1; k <= 3; k++) begin
      vq.push_back(mk(0, 4'b0000, 0, 0, 1, 0, 0, 0, 0, RUN, 32'h0));
      vq.push_back(mk(0, 4'b0010, 0, 0, 2, 1, 1, 0, 1, NONE, 32'h01010002 + (k << 8)));
      vq.push_back(mk(0, 4'b0010, 0, 0, 1, 1, 1, 0, 0, HOLD, 32'h01010002 + (k << 8)));
      vq.push_back(mk(0, 4'b0010, 0, 0, 2, 0, 0, 0, 0, RUN, 32'h0));
    end
    // release CPUs 0,3: best is CPU3 at 1, 1+2<3 false -> no preemption
    vq.push_back(mk(0, 4'b1011, 0, 0, 20, 1, 1, 0, 0, RUN, 32'h01010302));
    vq.push_back(mk(0, 4'b0010, 0, 0, 5, 1, 1, 0, 0, RUN, 32'h02010303));
    // one more CPU1 fault -> cnt1=4, then all healthy
    vq.push_back(mk(0, 4'b0000, 0, 0, 1, 0, 0, 0, 0, RUN, 32'h0));
    vq.push_back(mk(0, 4'b0010, 0, 0, 2, 1, 1, 0, 1, NONE, 32'h02010403));
    vq.push_back(mk(0, 4'hF, 0, 0, 1, 1, 1, 0, 0, HOLD, 32'h02010403));
    // holdoff suppresses preemption, then CPU2 (1+2<4) takes over
    vq.push_back(mk(0, 4'hF, 0, 0, 15, 1, 1, 0, 0, HOLD, 32'h02010403));
    vq.push_back(mk(0, 4'hF, 0, 0, 1, 1, 1, 0, 0, RUN,  32'h02010403));
    vq.push_back(mk(0, 4'hF, 0, 0, 1, 1, 2, 1, 0, HOLD, 32'h02010403));
    vq.push_back(mk(0, 4'hF, 0, 0, 1, 1, 2, 0, 0, HOLD, 32'h02010403));
    // forced onto faulted CPU3, counters cleared
    vq.push_back(mk(0, 4'b0111, 1, 3, 1, 1, 3, 1, 0, FORCED, 32'h0));
    vq.push_back(mk(0, 4'b0111, 1, 3, 4, 1, 3, 0, 0, FORCED, 32'h0));
    // drop force: HOLD, then failover 3 -> 0
    vq.push_back(mk(0, 4'b0111, 0, 0, 1, 1, 3, 0, 0, HOLD, 32'h0));
    vq.push_back(mk(0, 4'b0111, 0, 0, 1, 1, 0, 1, 0, HOLD, 32'h0));
    // all faulted -> NONE with sel held, then CPU2 recovers
    vq.push_back(mk(0, 4'b0000, 0, 0, 2, 1, 0, 0, 0, HOLD, 32'h0));
    vq.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 0, 0, 1, NONE, 32'h00010101));
    vq.push_back(mk(0, 4'b0100, 0, 0, 2, 1, 0, 0, 1, NONE, 32'h00010101));
    vq.push_back(mk(0, 4'b0100, 0, 0, 1, 1, 2, 1, 0, HOLD, 32'h00010101));
    // reset mid-HOLD, then mid-FORCED
    vq.push_back(mk(1, 4'hF, 0, 0, 1, 1, 0, 0, 0, RUN,    32'h0));
    vq.push_back(mk(0, 4'hF, 1, 2, 1, 1, 2, 1, 0, FORCED, 32'h0));
    vq.push_back(mk(1, 4'hF, 1, 2, 1, 1, 0, 0, 0, RUN,    32'h0));
    vq.push_back(mk(0, 4'hF, 0, 0, 3, 1, 0, 0, 0, RUN,    32'h0));

    foreach (vq[k]) begin
      v = vq[k];
      rst = v.r;
      bus.io_n = v.io;
      bus.force_swi = v.fs;
      bus.force_sel = v.fsel;
      for (int t = 0; t < v.n; t++) tick();
      if (v.chk) begin
        oh = 4'b0001 << v.sel;
        check($sformatf("row%0d sel", k),       32'(bus.sel),          32'(v.sel));
        check($sformatf("row%0d sel_oh", k),    32'(bus.sel_oh),       32'(oh));
        check($sformatf("row%0d pulse", k),     32'(bus.switch_pulse), 32'(v.p));
        check($sformatf("row%0d all_fault", k), 32'(bus.all_fault),    32'(v.af));
        check($sformatf("row%0d state", k),     32'(dut.state_q),      32'(v.st));
        check($sformatf("row%0d err_cnt", k),   bus.err_cnt,           v.cnt);
      end
    end

    // 3-CPU instance: force_sel=3 is out of range and leaves sel alone
    bus3.force_swi = 1'b1;
    bus3.force_sel = 2'd3;
    tick();
    check("n3 illegal sel",   32'(bus3.sel),          32'd0);
    check("n3 illegal pulse", 32'(bus3.switch_pulse), 32'd0);
    check("n3 illegal state", 32'(dut3.state_q),      32'(FORCED));
    bus3.force_sel = 2'd2;
    tick();
    check("n3 legal sel",     32'(bus3.sel),          32'd2);
    check("n3 legal sel_oh",  32'(bus3.sel_oh),       32'h4);
    check("n3 legal pulse",   32'(bus3.switch_pulse), 32'd1);
    bus3.force_swi = 1'b0;
    tick();
    check("n3 release state", 32'(dut3.state_q),      32'(HOLD));

    // saturation: cnt1=10, then drive CPU2 to 255 and watch it halve
    for (int i = 0; i < 10; i++) pulse(1);
    tick();
    check("sat cnt1 10", bus.err_cnt, 32'h00000A00);
    for (int i = 0; i < 255; i++) pulse(2);
    check("sat cnt2 254", bus.err_cnt, 32'h00FE0A00);
    tick();
    check("sat cnt2 255", bus.err_cnt, 32'h00FF0A00);
    tick();
    check("sat halved", bus.err_cnt, 32'h007F0500);
    pulse(2);
    tick();
    check("sat next evt", bus.err_cnt, 32'h00800500);
    check("sat sel",      32'(bus.sel),     32'd0);
    check("sat state",    32'(dut.state_q), 32'(RUN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
